truth_table_sweep_ctrl: RTL and testbench

TRUTH_TABLE_SWEEP_CTRL -- requirements
Module: truth_table_sweep_ctrl

---
 rtl/truth_table_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweep_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// truth_table_sweep_ctrl
//
// Purpose:
//   Walks a 4-input combinational DUT through all 16 input vectors and
//   compares its output against a golden 16-entry truth table. Each vector is
//   held for SETTLE cycles (DRIVE) and then sampled for one cycle (SAMPLE).
//   The block counts mismatches and records the first failing vector. It
//   raises a one-cycle done pulse with a pass/fail verdict at the end.
//
// Parameters:
//   SETTLE      cycles each vector is held before dut_f is sampled (1..15)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous, active-high reset
//   start       sweep request (accepted only in IDLE)
//   expected    golden truth table, bit i = expected F for vector i
//   dut_f       output F of the DUT under test
//   vec         DUT input vector {A,B,C,D}, A = vec[3]
//   busy        high while the sweep is in DRIVE or SAMPLE
//   done        one-cycle pulse in the DONE state
//   pass        last sweep finished with zero mismatches
//   err_count   mismatch count of the last or current sweep (0..16)
//   first_fail  first mismatching vector (0 when fail_valid = 0)
//   fail_valid  first_fail holds a valid vector
// ---------------------------------------------------------------------------
module truth_table_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        dut_f,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  // The settle counter counts down from SETTLE-1 to 0, which gives exactly
  // SETTLE cycles in DRIVE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_expected;
  logic [3:0]  r_settle;
  logic [3:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_err_count;
  logic [3:0]  r_first_fail;
  logic        r_fail_valid;

  logic        w_mismatch;
  logic [4:0]  w_err_next;

  assign w_mismatch = (dut_f != r_expected[r_vec]);

  // At most 16 samples occur per sweep, so the count cannot exceed 16.
  // The saturation guard keeps it bounded even if that ever changes.
  assign w_err_next = (w_mismatch && (r_err_count != 5'd16)) ?
                      (r_err_count + 5'd1) : r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_expected   <= '0;
      r_settle     <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_first_fail <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_expected   <= expected;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_vec        <= '0;
            r_settle     <= SETTLE_LOAD;
            r_busy       <= 1'b1;
            r_state      <= DRIVE;
          end
        end

        DRIVE: begin
          if (r_settle == 4'd0) begin
            r_state <= SAMPLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end

        SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_first_fail <= r_vec;
            r_fail_valid <= 1'b1;
          end
          if (r_vec == 4'd15) begin
            // The verdict is computed from the count that includes this final
            // sample, so pass is already valid alongside the done pulse.
            r_pass  <= (w_err_next == 5'd0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_vec    <= r_vec + 4'd1;
            r_settle <= SETTLE_LOAD;
            r_state  <= DRIVE;
          end
        end

        DONE: begin
          r_vec   <= '0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweep_ctrl
//
// Purpose:
//   Self-checking bench for truth_table_sweep_ctrl. It applies a table of
//   {golden table, DUT behaviour, expected verdict} records in a loop. It also
//   runs hand-written sequences for start re-pulsing, mid-sweep reset and
//   SETTLE=3 timing.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_truth_table_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with SETTLE = 1
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic        dut_f;
  logic [3:0]  vec;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic        fail_valid;

  // DUT behaviour: 0 = F=~(A|B|~C), 1 = stuck at 0, 2 = stuck at 1
  logic [1:0]  mode;

  always_comb begin
    dut_f = 1'b0;
    case (mode)
      2'd0:    dut_f = ~(vec[3] | vec[2] | ~vec[1]);
      2'd1:    dut_f = 1'b0;
      default: dut_f = 1'b1;
    endcase
  end

  truth_table_sweep_ctrl #(.SETTLE(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .expected   (expected),
    .dut_f      (dut_f),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  // Instance with SETTLE = 3
  logic        rst3;
  logic        start3;
  logic [15:0] expected3;
  logic        dut_f3;
  logic [3:0]  vec3;
  logic        busy3;
  logic        done3;
  logic        pass3;
  logic [4:0]  err_count3;
  logic [3:0]  first_fail3;
  logic        fail_valid3;

  assign dut_f3 = ~(vec3[3] | vec3[2] | ~vec3[1]);

  truth_table_sweep_ctrl #(.SETTLE(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst3),
    .start      (start3),
    .expected   (expected3),
    .dut_f      (dut_f3),
    .vec        (vec3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err_count3),
    .first_fail (first_fail3),
    .fail_valid (fail_valid3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [15:0] tbl;
    logic [1:0]  m;
    int          err;
    int          ff;
    int          fv;
    int          ps;
  } tv_t;

  tv_t tv[10];

  // Starts a sweep and returns the cycle index (1 = first cycle after the
  // start edge) at which done is seen; 200 means it never came.
  task automatic run_sweep(input logic [15:0] tbl, output int lat);
    @(negedge clk);
    expected = tbl;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_cycle1", int'(busy), 1);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int dcyc;

    tv[0] = '{16'h000C, 2'd0,  0,  0, 0, 1};
    tv[1] = '{16'h000C, 2'd1,  2,  2, 1, 0};
    tv[2] = '{16'hFFFF, 2'd1, 16,  0, 1, 0};
    tv[3] = '{16'h0000, 2'd2, 16,  0, 1, 0};
    tv[4] = '{16'h0004, 2'd0,  1,  3, 1, 0};
    tv[5] = '{16'h8000, 2'd2, 15,  0, 1, 0};
    tv[6] = '{16'h0000, 2'd0,  2,  2, 1, 0};
    tv[7] = '{16'h8000, 2'd1,  1, 15, 1, 0};
    tv[8] = '{16'h0000, 2'd1,  0,  0, 0, 1};
    tv[9] = '{16'hFFFF, 2'd2,  0,  0, 0, 1};

    rst       = 1'b1;
    start     = 1'b0;
    expected  = 16'h0;
    mode      = 2'd0;
    rst3      = 1'b1;
    start3    = 1'b0;
    expected3 = 16'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vec",  int'(vec), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err",  int'(err_count), 0);
    check("rst_ff",   int'(first_fail), 0);
    check("rst_fv",   int'(fail_valid), 0);
    rst = 1'b0;

    // Table-driven sweeps
    for (int i = 0; i < 10; i++) begin
      mode = tv[i].m;
      run_sweep(tv[i].tbl, lat);
      check($sformatf("v%0d_latency", i), lat, 33);
      check($sformatf("v%0d_err", i), int'(err_count), tv[i].err);
      check($sformatf("v%0d_ff", i), int'(first_fail), tv[i].ff);
      check($sformatf("v%0d_fv", i), int'(fail_valid), tv[i].fv);
      check($sformatf("v%0d_pass", i), int'(pass), tv[i].ps);
      check($sformatf("v%0d_busy_done", i), int'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_vec_idle", i), int'(vec), 0);
      check($sformatf("v%0d_err_hold", i), int'(err_count), tv[i].err);
      check($sformatf("v%0d_pass_hold", i), int'(pass), tv[i].ps);
      $display("sweep %0d: table=%h mode=%0d err=%0d ff=%0d fv=%0d pass=%0d lat=%0d",
               i, tv[i].tbl, tv[i].m, err_count, first_fail, fail_valid, pass, lat);
    end

    // start re-pulsed at cycles 5, 20, 33 with expected changed mid-sweep
    mode = 2'd0;
    ndone = 0;
    dcyc  = 0;
    @(negedge clk);
    expected = 16'h000C;
    start    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = c;
      end
      start = (c == 5 || c == 20 || c == 33);
      if (c == 5)  expected = 16'hFFFF;
      if (c == 20) expected = 16'h0000;
    end
    start = 1'b0;
    check("repulse_done_count", ndone, 1);
    check("repulse_done_cycle", dcyc, 33);
    check("repulse_pass", int'(pass), 1);
    check("repulse_err", int'(err_count), 0);
    check("repulse_busy", int'(busy), 0);
    $display("repulse: done_pulses=%0d done_cycle=%0d pass=%0d err=%0d",
             ndone, dcyc, pass, err_count);

    // rst pulsed 10 cycles into a sweep
    mode = 2'd1;
    @(negedge clk);
    expected = 16'hFFFF;
    start    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_err_before", int'(err_count), 4);
    check("midrst_vec_before", int'(vec), 4);
    check("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_vec",  int'(vec), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_pass", int'(pass), 0);
    check("midrst_err",  int'(err_count), 0);
    check("midrst_ff",   int'(first_fail), 0);
    check("midrst_fv",   int'(fail_valid), 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_idle_busy", int'(busy), 0);
    mode = 2'd0;
    run_sweep(16'h000C, lat);
    check("postrst_latency", lat, 33);
    check("postrst_pass", int'(pass), 1);
    $display("midrst: aborted, following sweep lat=%0d pass=%0d", lat, pass);

    // SETTLE = 3 timing
    rst3 = 1'b0;
    ndone = 0;
    dcyc  = 0;
    @(negedge clk);
    expected3 = 16'h000C;
    start3    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (c <= 64) begin
        check($sformatf("s3_vec_c%0d", c), int'(vec3), (c - 1) / 4);
      end
      if (done3) begin
        ndone++;
        dcyc = c;
      end
    end
    check("s3_done_count", ndone, 1);
    check("s3_done_cycle", dcyc, 65);
    check("s3_pass", int'(pass3), 1);
    check("s3_err",  int'(err_count3), 0);
    $display("settle3: done_cycle=%0d pass=%0d err=%0d", dcyc, pass3, err_count3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
